// File: rtl/multiplexer_n_mto1_arbiter.sv
// Registered M:1 multiplexer with valid/ready per channel and fixed-priority or round-robin arbitration.
// One cycle latency, one word per cycle; in_ready is withheld while the output register is stalled.
module multiplexer_n_mto1_arbiter #(
  parameter int N    = 4,
  parameter int M    = 4,
  parameter int MODE = 1,
  localparam int SW  = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  output logic [N-1:0]    channel_out,
  output logic [SW-1:0]   out_select,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]  r_data;
  logic [SW-1:0] r_sel;
  logic          r_valid;
  logic [SW-1:0] r_ptr;

  logic [N-1:0]  w_words [M];
  logic          w_load;
  logic          w_any;
  logic [SW-1:0] w_gidx;
  logic [M-1:0]  w_grant;
  logic [SW-1:0] w_base;
  logic [SW:0]   w_sum;

  for (genvar g = 0; g < M; g++) begin : g_unpack
    assign w_words[g] = in_data[g*N +: N];
  end

  assign w_load = ~r_valid | out_ready;
  assign w_base = (MODE == 1) ? r_ptr : '0;

  // Search upward from the base index with wrap; MODE 0 always starts at channel 0.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_sum  = '0;
    for (int k = 0; k < M; k++) begin
      w_sum = {1'b0, w_base} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(M)) w_sum = w_sum - (SW+1)'(M);
      if (!w_any && in_valid[w_sum[SW-1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_sum[SW-1:0];
      end
    end
  end

  assign w_grant  = w_any ? (M'(1) << w_gidx) : '0;
  assign in_ready = w_grant & {M{w_load & ~reset}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_data  <= w_words[w_gidx];
        r_sel   <= w_gidx;
        r_valid <= 1'b1;
        if (MODE == 1) r_ptr <= (w_gidx == SW'(M-1)) ? '0 : w_gidx + SW'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign channel_out = r_data;
  assign out_select  = r_sel;
  assign out_valid   = r_valid;

endmodule

// File: tb/tb_multiplexer_n_mto1_arbiter.sv
// Directed bench: one round-robin and one fixed-priority instance driven by shared stimulus.
module tb_multiplexer_n_mto1_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rr_in_ready, fp_in_ready;
  logic [3:0]  rr_out, fp_out;
  logic [1:0]  rr_sel, fp_sel;
  logic        rr_vld, fp_vld;

  int n_cmp = 0;
  int n_err = 0;

  multiplexer_n_mto1_arbiter #(.N(4), .M(4), .MODE(1)) u_dut_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .channel_out(rr_out), .out_select(rr_sel),
    .out_valid(rr_vld), .out_ready(out_ready)
  );

  multiplexer_n_mto1_arbiter #(.N(4), .M(4), .MODE(0)) u_dut_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .channel_out(fp_out), .out_select(fp_sel),
    .out_valid(fp_vld), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_vld", 32'(rr_vld), 0);
    chk("rst_out", 32'(rr_out), 0);
    chk("rst_sel", 32'(rr_sel), 0);
    chk("rst_rdy", 32'(rr_in_ready), 0);
    @(negedge clk);
    reset = 1'b0;

    // Single source on channel 2
    in_valid  = 4'b0100;
    in_data   = 16'h0A00;
    out_ready = 1'b1;
    #1 chk("single_rdy", 32'(rr_in_ready), 32'h4);
    @(negedge clk);
    chk("single_vld", 32'(rr_vld), 1);
    chk("single_out", 32'(rr_out), 32'hA);
    chk("single_sel", 32'(rr_sel), 2);

    // Asynchronous reset while holding a word
    #2 reset = 1'b1;
    #1;
    chk("midrst_vld", 32'(rr_vld), 0);
    chk("midrst_out", 32'(rr_out), 0);
    chk("midrst_sel", 32'(rr_sel), 0);
    chk("midrst_rdy", 32'(rr_in_ready), 0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin with all channels valid
    in_valid = 4'b1111;
    in_data  = 16'h4321;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_rdy", 32'(rr_in_ready), 32'(1 << (i % 4)));
      @(negedge clk);
      chk("rr_sel", 32'(rr_sel), 32'(i % 4));
      chk("rr_out", 32'(rr_out), 32'(i % 4 + 1));
      chk("rr_vld", 32'(rr_vld), 1);
    end

    // Fixed priority: ch1 always beats ch3
    in_valid = 4'b1010;
    in_data  = 16'h7050;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fp_rdy", 32'(fp_in_ready), 32'h2);
      @(negedge clk);
      chk("fp_sel", 32'(fp_sel), 1);
      chk("fp_out", 32'(fp_out), 5);
    end

    // Backpressure: five stalled cycles, then drain and refill together
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    in_data   = 16'h0009;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_fp_rdy", 32'(fp_in_ready), 0);
      chk("bp_rr_rdy", 32'(rr_in_ready), 0);
      @(negedge clk);
      chk("bp_vld", 32'(fp_vld), 1);
      chk("bp_out", 32'(fp_out), 5);
      chk("bp_sel", 32'(fp_sel), 1);
    end
    out_ready = 1'b1;
    #1 chk("drain_rdy", 32'(fp_in_ready), 32'h1);
    @(negedge clk);
    chk("drain_vld", 32'(fp_vld), 1);
    chk("drain_out", 32'(fp_out), 9);
    chk("drain_sel", 32'(fp_sel), 0);
    chk("drain_rr_out", 32'(rr_out), 9);

    // Wrap: ch3 transfers, idle cycle, then ch0 wins over ch3
    in_valid = 4'b1000;
    in_data  = 16'hC000;
    #1 chk("wrap_rdy", 32'(rr_in_ready), 32'h8);
    @(negedge clk);
    chk("wrap_sel", 32'(rr_sel), 3);
    chk("wrap_out", 32'(rr_out), 32'hC);
    in_valid = 4'b0000;
    #1 chk("idle_rdy", 32'(rr_in_ready), 0);
    @(negedge clk);
    chk("idle_vld", 32'(rr_vld), 0);
    chk("idle_out", 32'(rr_out), 32'hC);
    chk("idle_sel", 32'(rr_sel), 3);
    chk("idle_fp_vld", 32'(fp_vld), 0);
    in_valid = 4'b1001;
    in_data  = 16'hE006;
    #1 chk("after_rdy", 32'(rr_in_ready), 32'h1);
    @(negedge clk);
    chk("after_sel", 32'(rr_sel), 0);
    chk("after_out", 32'(rr_out), 6);
    chk("after_vld", 32'(rr_vld), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
